// File: rtl/universal_shift_register_pkg.sv
// Shared encodings for the universal shift register: shift/rotate modes and burst FSM states.
package universal_shift_register_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD     = 3'b000,
      MODE_SHL      = 3'b001,
      MODE_SHR      = 3'b010,
      MODE_ROL      = 3'b011,
      MODE_ROR      = 3'b100,
      MODE_ASR      = 3'b101,
      MODE_LOAD     = 3'b110,
      MODE_HOLD_ALT = 3'b111
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Only shift and rotate modes may be repeated by the burst engine.
   function automatic logic is_burst_mode(input logic [2:0] m);
      return (m >= 3'(MODE_SHL)) && (m <= 3'(MODE_ASR));
   endfunction

endpackage

// File: rtl/universal_shift_register_shift_step.sv
// Combinational single step of the shift register: next value and the bit pushed out.
module universal_shift_register_shift_step
   import universal_shift_register_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] value_i,
   input  logic [2:0]   mode_i,
   input  logic         serial_i,
   input  logic [N-1:0] par_i,
   output logic [N-1:0] next_c_o,
   output logic         expel_c_o,
   output logic         expel_vld_c_o
);

   always_comb begin
      next_c_o      = value_i;
      expel_c_o     = 1'b0;
      expel_vld_c_o = 1'b0;
      case (mode_e'(mode_i))
         MODE_SHL: begin
            next_c_o      = {value_i[N-2:0], serial_i};
            expel_c_o     = value_i[N-1];
            expel_vld_c_o = 1'b1;
         end
         MODE_SHR: begin
            next_c_o      = {serial_i, value_i[N-1:1]};
            expel_c_o     = value_i[0];
            expel_vld_c_o = 1'b1;
         end
         MODE_ROL: begin
            next_c_o      = {value_i[N-2:0], value_i[N-1]};
            expel_c_o     = value_i[N-1];
            expel_vld_c_o = 1'b1;
         end
         MODE_ROR: begin
            next_c_o      = {value_i[0], value_i[N-1:1]};
            expel_c_o     = value_i[0];
            expel_vld_c_o = 1'b1;
         end
         MODE_ASR: begin
            next_c_o      = {value_i[N-1], value_i[N-1:1]};
            expel_c_o     = value_i[0];
            expel_vld_c_o = 1'b1;
         end
         MODE_LOAD: next_c_o = par_i;
         default:   next_c_o = value_i;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with direct single-step ops and a counted burst engine.
module universal_shift_register
   import universal_shift_register_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [2:0]    mode,
   input  logic          serial_in,
   input  logic [N-1:0]  par_in,
   input  logic          start,
   input  logic [CW-1:0] count,
   output logic [N-1:0]  reg_out,
   output logic          serial_out,
   output logic          busy,
   output logic          done
);

   state_e        state_q, state_d;
   logic [2:0]    run_mode_q, run_mode_d;
   logic [CW-1:0] remaining_q, remaining_d;
   logic [N-1:0]  reg_q, reg_d;
   logic          sout_q, sout_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [2:0]    step_mode_c;
   logic [N-1:0]  step_next_c;
   logic          step_expel_c;
   logic          step_expel_vld_c;
   logic          start_ok_c;

   // In RUN the latched mode drives the shared step logic; external mode is ignored.
   assign step_mode_c = (state_q == ST_RUN) ? run_mode_q : mode;
   assign start_ok_c  = start && is_burst_mode(mode) && (count != '0);

   universal_shift_register_shift_step #(.N(N)) u_shift_step (
      .value_i       (reg_q),
      .mode_i        (step_mode_c),
      .serial_i      (serial_in),
      .par_i         (par_in),
      .next_c_o      (step_next_c),
      .expel_c_o     (step_expel_c),
      .expel_vld_c_o (step_expel_vld_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         run_mode_q  <= 3'(MODE_HOLD);
         remaining_q <= '0;
         reg_q       <= '0;
         sout_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_mode_q  <= run_mode_d;
         remaining_q <= remaining_d;
         reg_q       <= reg_d;
         sout_q      <= sout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      run_mode_d  = run_mode_q;
      remaining_d = remaining_q;
      reg_d       = reg_q;
      sout_d      = sout_q;
      busy_d      = busy_q;
      done_d      = done_q;
      if (en) begin
         done_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_ok_c) begin
                  run_mode_d  = mode;
                  remaining_d = count;
                  busy_d      = 1'b1;
                  state_d     = ST_RUN;
               end else begin
                  reg_d = step_next_c;
                  if (step_expel_vld_c) sout_d = step_expel_c;
               end
            end
            ST_RUN: begin
               reg_d       = step_next_c;
               sout_d      = step_expel_c;
               remaining_d = remaining_q - CW'(1);
               if (remaining_q == CW'(1)) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign reg_out    = reg_q;
   assign serial_out = sout_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed scoreboard bench for universal_shift_register (N=8).
module tb_universal_shift_register;

   localparam int unsigned N  = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b0;
   logic [2:0]    mode = 3'b000;
   logic          serial_in = 1'b0;
   logic [N-1:0]  par_in = '0;
   logic          start = 1'b0;
   logic [CW-1:0] count = '0;
   logic [N-1:0]  reg_out;
   logic          serial_out;
   logic          busy;
   logic          done;

   typedef struct {
      string        tag;
      logic [N-1:0] r;
      logic         so;
      logic         bz;
      logic         dn;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   universal_shift_register #(.N(N), .CW(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .serial_in  (serial_in),
      .par_in     (par_in),
      .start      (start),
      .count      (count),
      .reg_out    (reg_out),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [N-1:0] r, input logic so,
                           input logic bz, input logic dn);
      exp_t e;
      e.tag = tag; e.r = r; e.so = so; e.bz = bz; e.dn = dn;
      exp_q.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty observed %0d expected >0", exp_q.size());
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         assert (reg_out === e.r) else begin
            errors++;
            $error("FAIL %s reg_out observed %h expected %h", e.tag, reg_out, e.r);
         end
         checks++;
         assert (serial_out === e.so) else begin
            errors++;
            $error("FAIL %s serial_out observed %b expected %b", e.tag, serial_out, e.so);
         end
         checks++;
         assert (busy === e.bz) else begin
            errors++;
            $error("FAIL %s busy observed %b expected %b", e.tag, busy, e.bz);
         end
         checks++;
         assert (done === e.dn) else begin
            errors++;
            $error("FAIL %s done observed %b expected %b", e.tag, done, e.dn);
         end
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
   task automatic cyc(input logic e, input logic [2:0] m, input logic si, input logic [N-1:0] p,
                      input logic st, input logic [CW-1:0] c, input string tag,
                      input logic [N-1:0] er, input logic eso, input logic ebz, input logic edn);
      en = e; mode = m; serial_in = si; par_in = p; start = st; count = c;
      push_exp(tag, er, eso, ebz, edn);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         cyc(1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
             4'($urandom_range(1, 8)), "reset", 8'h00, 1'b0, 1'b0, 1'b0);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 3'($urandom_range(1, 6)), 1'b1, 8'hFF, 1'b1, 4'd3,
             "en_low", 8'h00, 1'b0, 1'b0, 1'b0);
      end

      // Direct ops
      cyc(1'b1, 3'b110, 1'b0, 8'hA5, 1'b0, 4'd0, "load_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'b001, 1'b1, 8'h00, 1'b0, 4'd0, "shl_si1", 8'h4B, 1'b1, 1'b0, 1'b0);

      // Rotate-right burst of 3 from 0x81
      cyc(1'b1, 3'b110, 1'b0, 8'h81, 1'b0, 4'd0, "load_81", 8'h81, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 3'b100, 1'b0, 8'h00, 1'b1, 4'd3, "ror_start", 8'h81, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 3'b110, 1'b1, 8'hFF, 1'b1, 4'd7, "ror_e1", 8'hC0, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 3'b110, 1'b1, 8'hFF, 1'b0, 4'd7, "ror_e2", 8'h60, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "ror_e3", 8'h30, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "ror_after", 8'h30, 1'b0, 1'b0, 1'b0);

      // Arithmetic-right burst of 2 stretched by en=0
      cyc(1'b1, 3'b110, 1'b0, 8'h90, 1'b0, 4'd0, "load_90", 8'h90, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'b101, 1'b1, 8'h00, 1'b1, 4'd2, "asr_start", 8'h90, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b110, 1'b1, 8'h00, 1'b0, 4'd0, "asr_e1", 8'hC8, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 3'b110, 1'b1, 8'h00, 1'b0, 4'd0, "asr_stall1", 8'hC8, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 3'b110, 1'b1, 8'h00, 1'b0, 4'd0, "asr_stall2", 8'hC8, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b110, 1'b1, 8'h00, 1'b0, 4'd0, "asr_e2", 8'hE4, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "asr_after", 8'hE4, 1'b0, 1'b0, 1'b0);

      // Rotate-left by N restores the value
      cyc(1'b1, 3'b110, 1'b0, 8'h3C, 1'b0, 4'd0, "load_3c", 8'h3C, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'b011, 1'b0, 8'h00, 1'b1, 4'd8, "rol_start", 8'h3C, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 4'd0, "rol_1", 8'h78, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 4'd0, "rol_2", 8'hF0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "rol_3", 8'hE1, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "rol_4", 8'hC3, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "rol_5", 8'h87, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "rol_6", 8'h0F, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "rol_7", 8'h1E, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "rol_8", 8'h3C, 1'b0, 1'b0, 1'b1);
      // Start with count=0 in the done cycle: ignored, direct rotate executes
      cyc(1'b1, 3'b011, 1'b0, 8'h00, 1'b1, 4'd0, "start_cnt0", 8'h78, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'b110, 1'b0, 8'h55, 1'b1, 4'd3, "start_load", 8'h55, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "idle_nodone", 8'h55, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a shift-left burst of 5
      cyc(1'b1, 3'b110, 1'b0, 8'h01, 1'b0, 4'd0, "load_01", 8'h01, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'b001, 1'b1, 8'h00, 1'b1, 4'd5, "shl_start", 8'h01, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 4'd0, "shl_e1", 8'h03, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 4'd0, "shl_e2", 8'h07, 1'b0, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      push_exp("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      check_pop();
      cyc(1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 4'd0, "reset_hold", 8'h00, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      cyc(1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 4'd0, "post_rst1", 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 4'd0, "post_rst2", 8'h00, 1'b0, 1'b0, 1'b0);

      // Burst accepted normally after the aborted one
      cyc(1'b1, 3'b110, 1'b0, 8'h81, 1'b0, 4'd0, "reload_81", 8'h81, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 3'b100, 1'b0, 8'h00, 1'b1, 4'd1, "ror1_start", 8'h81, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "ror1_e1", 8'hC0, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 4'd0, "ror1_after", 8'hC0, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
